// File: rtl/sticky_event_bank.sv
// Bank of WIDTH sticky event flags with write-1-to-clear, per-channel saturating
// event counters, sticky overflow flags and a masked interrupt output.
module sticky_event_bank #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int EDGE  = 0,
    parameter int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] clr,
    input  logic [WIDTH-1:0] mask,
    input  logic [SEL_W-1:0] cnt_sel,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] ovf,
    output logic [CNT_W-1:0] cnt_out,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] d_prev_q, d_prev_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] ev;

    always_comb begin
        d_prev_d = d;
        if (!en) begin
            ev = '0;
        end else if (EDGE != 0) begin
            ev = d & ~d_prev_q;
        end else begin
            ev = d;
        end

        // An event beats a clear on the flag, but a clear always wins on overflow.
        for (int i = 0; i < WIDTH; i++) begin
            q_d[i]   = ev[i] | (q_q[i] & ~clr[i]);
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            if (clr[i]) begin
                cnt_d[i] = ev[i] ? CNT_W'(1) : '0;
                ovf_d[i] = 1'b0;
            end else if (ev[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            d_prev_q <= '0;
            q_q      <= '0;
            ovf_q    <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            d_prev_q <= d_prev_d;
            q_q      <= q_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    // Selecting a channel beyond WIDTH reads as zero.
    always_comb begin
        cnt_out = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (32'(cnt_sel) == i) begin
                cnt_out = cnt_q[i];
            end
        end
    end

    assign q   = q_q;
    assign ovf = ovf_q;
    assign irq = |(q_q & mask);

endmodule

// File: tb/tb_sticky_event_bank.sv
// Scoreboard bench for sticky_event_bank: level and edge instances share stimulus
// and are compared every cycle against a per-channel behavioural model.
module tb_sticky_event_bank;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic [7:0] d = '0;
   logic [7:0] clr = '0;
   logic [7:0] mask = '0;
   logic [2:0] cntSel = '0;

   logic [7:0] q0, ovf0, q1, ovf1;
   logic [3:0] cnt0, cnt1;
   logic       irq0, irq1;

   typedef struct {
      logic [7:0] q0;
      logic [7:0] ovf0;
      logic [3:0] cnt0;
      logic       irq0;
      logic [7:0] q1;
      logic [7:0] ovf1;
      logic [3:0] cnt1;
      logic       irq1;
   } exp_t;

   exp_t expQ[$];

   int checks = 0;
   int failures = 0;

   bit mq[2][8];
   bit movf[2][8];
   int mcnt[2][8];
   bit mprev[8];

   always #5 clk = ~clk;

   sticky_event_bank #(.WIDTH(8), .CNT_W(4), .EDGE(0)) dutLevel (
      .clk(clk), .rst(rst), .en(en), .d(d), .clr(clr), .mask(mask),
      .cnt_sel(cntSel), .q(q0), .ovf(ovf0), .cnt_out(cnt0), .irq(irq0)
   );

   sticky_event_bank #(.WIDTH(8), .CNT_W(4), .EDGE(1)) dutEdge (
      .clk(clk), .rst(rst), .en(en), .d(d), .clr(clr), .mask(mask),
      .cnt_sel(cntSel), .q(q1), .ovf(ovf1), .cnt_out(cnt1), .irq(irq1)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the model past the coming edge and queue the result.
   task automatic applyStimulus(input bit rstV, input bit enV, input logic [7:0] dV,
                                input logic [7:0] clrV, input logic [7:0] maskV, input logic [2:0] selV);
      exp_t e;
      logic [7:0] qv [2];
      logic [7:0] ov [2];
      @(negedge clk);
      rst = rstV; en = enV; d = dV; clr = clrV; mask = maskV; cntSel = selV;
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 8; i++) begin
            bit ev;
            ev = enV && dV[i] && (m == 0 || !mprev[i]);
            if (!rstV) begin
               mq[m][i] = 0; movf[m][i] = 0; mcnt[m][i] = 0;
            end else if (clrV[i]) begin
               mq[m][i] = ev;
               mcnt[m][i] = ev ? 1 : 0;
               movf[m][i] = 0;
            end else if (ev) begin
               mq[m][i] = 1;
               if (mcnt[m][i] == 15) movf[m][i] = 1;
               else mcnt[m][i] = mcnt[m][i] + 1;
            end
            qv[m][i] = mq[m][i];
            ov[m][i] = movf[m][i];
         end
      end
      for (int i = 0; i < 8; i++) mprev[i] = rstV ? dV[i] : 1'b0;
      e.q0 = qv[0]; e.ovf0 = ov[0]; e.cnt0 = 4'(mcnt[0][selV]); e.irq0 = |(qv[0] & maskV);
      e.q1 = qv[1]; e.ovf1 = ov[1]; e.cnt1 = 4'(mcnt[1][selV]); e.irq1 = |(qv[1] & maskV);
      expQ.push_back(e);
   endtask

   // Monitor: sample just after each edge and compare against the oldest queued entry.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput("level_q", 32'(q0), 32'(e.q0));
         checkOutput("level_ovf", 32'(ovf0), 32'(e.ovf0));
         checkOutput("level_cnt_out", 32'(cnt0), 32'(e.cnt0));
         checkOutput("level_irq", 32'(irq0), 32'(e.irq0));
         checkOutput("edge_q", 32'(q1), 32'(e.q1));
         checkOutput("edge_ovf", 32'(ovf1), 32'(e.ovf1));
         checkOutput("edge_cnt_out", 32'(cnt1), 32'(e.cnt1));
         checkOutput("edge_irq", 32'(irq1), 32'(e.irq1));
      end
   end

   initial begin
      int drain;
      // Reset with inputs active
      repeat (2) applyStimulus(0, 1, 8'hff, 8'h00, 8'hff, 3'd0);

      // Level count, saturation and clear on channel 0
      repeat (20) applyStimulus(1, 1, 8'h01, 8'h00, 8'h00, 3'd0);
      applyStimulus(1, 1, 8'h00, 8'h01, 8'h00, 3'd0);

      // Set/clear collision on channel 3
      repeat (5) applyStimulus(1, 1, 8'h08, 8'h00, 8'h00, 3'd3);
      applyStimulus(1, 1, 8'h08, 8'h08, 8'h00, 3'd3);
      applyStimulus(1, 1, 8'h00, 8'h00, 8'h00, 3'd3);

      // Edge pattern on channel 2, then again with the first edge disabled
      applyStimulus(1, 1, 8'h00, 8'hff, 8'h00, 3'd2);
      foreach (d[k]) begin end
      applyStimulus(1, 1, 8'h00, 8'h00, 8'h00, 3'd2);
      applyStimulus(1, 1, 8'h04, 8'h00, 8'h00, 3'd2);
      applyStimulus(1, 1, 8'h04, 8'h00, 8'h00, 3'd2);
      applyStimulus(1, 1, 8'h04, 8'h00, 8'h00, 3'd2);
      applyStimulus(1, 1, 8'h00, 8'h00, 8'h00, 3'd2);
      applyStimulus(1, 1, 8'h04, 8'h00, 8'h00, 3'd2);
      applyStimulus(1, 1, 8'h00, 8'hff, 8'h00, 3'd2);
      applyStimulus(1, 1, 8'h00, 8'h00, 8'h00, 3'd2);
      applyStimulus(1, 0, 8'h04, 8'h00, 8'h00, 3'd2);
      applyStimulus(1, 1, 8'h04, 8'h00, 8'h00, 3'd2);
      applyStimulus(1, 1, 8'h04, 8'h00, 8'h00, 3'd2);
      applyStimulus(1, 1, 8'h00, 8'h00, 8'h00, 3'd2);
      applyStimulus(1, 1, 8'h04, 8'h00, 8'h00, 3'd2);

      // Interrupt masking
      applyStimulus(1, 1, 8'h00, 8'hff, 8'h00, 3'd5);
      applyStimulus(1, 1, 8'h60, 8'h00, 8'h00, 3'd5);
      applyStimulus(1, 1, 8'h00, 8'h00, 8'h00, 3'd5);
      applyStimulus(1, 1, 8'h00, 8'h00, 8'h20, 3'd5);
      applyStimulus(1, 1, 8'h00, 8'h20, 8'h20, 3'd6);
      applyStimulus(1, 1, 8'h00, 8'h00, 8'h40, 3'd6);

      // Reset in the middle of counting
      applyStimulus(1, 1, 8'h00, 8'hff, 8'h00, 3'd1);
      repeat (7) applyStimulus(1, 1, 8'h02, 8'h00, 8'h00, 3'd1);
      applyStimulus(0, 1, 8'h02, 8'h00, 8'h00, 3'd1);
      repeat (3) applyStimulus(1, 1, 8'h02, 8'h00, 8'h00, 3'd1);

      // Randomised traffic with sparse clears and occasional resets
      for (int n = 0; n < 400; n++) begin
         applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
                       8'($urandom), 8'($urandom & $urandom & $urandom),
                       8'($urandom), 3'($urandom_range(0, 7)));
      end

      drain = 0;
      while (expQ.size() > 0 && drain < 10) begin
         @(negedge clk);
         drain++;
      end
      if (expQ.size() > 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", expQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/sticky_event_bank.md
# sticky_event_bank

Parametrised bank of WIDTH sticky event flags, the multi-channel successor to the single-bit sticky-set flop. Each channel captures level or rising-edge events on its input, holds the flag until a write-1-to-clear, and keeps a saturating per-channel event count with an overflow flag. A masked OR of the flags drives one interrupt line. The block sits between raw status/event sources and the register/interrupt logic.

## Interface
Parameters:
- WIDTH, 8, number of channels (1..32)
- CNT_W, 4, per-channel event counter width (1..16)
- EDGE, 0, 0 = level capture (d high is an event), 1 = rising-edge capture
- SEL_W, max(1, $clog2(WIDTH)), width of cnt_sel

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-low (sampled on posedge clk; 0 = reset)
- en  in  1  capture enable; when 0, no events are generated
- d  in  WIDTH  event inputs, one per channel
- clr  in  WIDTH  write-1-to-clear strobes for flag, counter and overflow of each channel
- mask  in  WIDTH  interrupt enable per channel
- cnt_sel  in  SEL_W  channel select for cnt_out
- q  out  WIDTH  sticky event flags (registered)
- ovf  out  WIDTH  sticky counter-overflow flags (registered)
- cnt_out  out  CNT_W  event count of the selected channel
- irq  out  1  interrupt, OR of (q & mask)

## Operation
- Event term, per channel i:
  - EDGE=0: e[i] = en & d[i]
  - EDGE=1: e[i] = en & d[i] & ~d_prev[i]
- d_prev: WIDTH-bit register loading d every cycle regardless of en. Reset value 0, so a d[i] held high through reset gives one event on the first enabled cycle after reset.
- Flag q[i], next state (priority order):
  - reset → 0
  - e[i] → 1 (set wins over a simultaneous clr[i])
  - clr[i] → 0
  - otherwise hold
- Counter cnt[i], CNT_W bits, next state:
  - reset → 0
  - clr[i] & e[i] → 1
  - clr[i] → 0
  - e[i] & cnt[i] == 2^CNT_W−1 → hold (saturate)
  - e[i] → cnt[i] + 1
  - otherwise hold
- Overflow ovf[i], next state:
  - reset → 0
  - clr[i] → 0, even with a simultaneous event
  - e[i] & cnt[i] saturated → 1
  - otherwise hold
- cnt_out = cnt[cnt_sel] when cnt_sel < WIDTH, else 0. Combinational from registered state.
- irq = |(q & mask). Combinational from registered q and the live mask input.
- Channels are fully independent; no cross-channel interaction.

## Timing
- Reset values: q = 0, ovf = 0, all cnt = 0, d_prev = 0, so cnt_out = 0 and irq = 0. All apply in the cycle after rst is sampled low.
- Latency, event → q, cnt, ovf: one cycle; visible after the posedge that samples the event.
- Latency, q → irq: zero cycles. mask → irq: zero cycles (combinational).
- clr takes effect at the sampling posedge; q and ovf read 0 in the next cycle unless an event set them in the same cycle.
- Reset mid-operation: all state clears on that edge, overriding events and clears. There is no reset-driven event on release except the d_prev behaviour described above.
- EDGE=1 with d held high: exactly one event per low→high transition. An edge arriving while en=0 is lost, and is not replayed when en is asserted.
- EDGE=0 with d held high for N enabled cycles: N events, counter saturates at 2^CNT_W−1.

## Test plan
- Reset: hold rst=0 for 2 cycles with d=all ones and en=1 → q=0, ovf=0, cnt_out=0, irq=0 throughout reset.
- Level count and saturate (WIDTH=8, CNT_W=4, EDGE=0, cnt_sel=0): d[0]=1 for 20 enabled cycles.
  - q[0]=1 one cycle after the first event.
  - cnt_out reaches 15 after 15 events and holds.
  - ovf[0]=1 after the 16th event.
  - Pulse clr[0] with d[0]=0 → q[0]=0, ovf[0]=0, cnt_out=0.
- Set/clear collision: q[3]=1 and cnt[3]=5, then clr[3]=1 with d[3]=1 in the same cycle → q[3]=1, cnt[3]=1, ovf[3]=0.
- Edge mode (EDGE=1): d[2] driven 0,1,1,1,0,1 with en=1 → cnt[2]=2.
  - Repeat with en=0 during the first rising edge → cnt[2]=1.
- Interrupt masking: set q[5] and q[6] with mask=0x00 → irq=0.
  - mask=0x20 → irq=1 in the same cycle.
  - clr=0x20 → irq=0 next cycle although q[6]=1.
- Reset mid-count: cnt[1]=7 with events ongoing; assert rst=0 for one cycle → all cnt=0, q=0 next cycle, and counting resumes from 1 on the next event.
